// File: rtl/video_timing_if.sv
// Raster timing bundle: coordinates, syncs, enable, strobes and frame count.
interface video_timing_if #(
    parameter int COORDSPC = 16
);
    logic signed [COORDSPC-1:0] sx;
    logic signed [COORDSPC-1:0] sy;
    logic                       hsync;
    logic                       vsync;
    logic                       video_enable;
    logic                       frame_start;
    logic                       line_start;
    logic [15:0]                frame_count;

    modport master (
        output sx, sy, hsync, vsync, video_enable,
        output frame_start, line_start, frame_count
    );

    modport slave (
        input sx, sy, hsync, vsync, video_enable,
        input frame_start, line_start, frame_count
    );
endinterface

// File: rtl/video_timing.sv
// Raster timing generator: signed pixel coordinates with blanking before
// the visible origin, plus syncs, enable and strobes aligned to them.
module video_timing #(
    parameter int COORDSPC = 16,
    parameter int H_RES    = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_RES    = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1
) (
    input  logic           video_clk_pix,
    input  logic           video_rst_pix,
    video_timing_if.master vid
);
    localparam int H_STA = -(H_FP + H_SYNC + H_BP);
    localparam int V_STA = -(V_FP + V_SYNC + V_BP);
    localparam longint C_MAX = (longint'(1) <<< (COORDSPC - 1)) - 1;
    localparam longint C_MIN = -C_MAX - 1;

    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_RES < 1 || V_RES < 1 ||
        longint'(H_STA) < C_MIN || longint'(V_STA) < C_MIN ||
        longint'(H_RES - 1) > C_MAX ||
        longint'(V_RES - 1) > C_MAX) begin : g_bad_params
        $error("video_timing: illegal timing parameters");
    end

    typedef logic signed [COORDSPC-1:0] coord_t;

    localparam coord_t L_ONE  = coord_t'(1);
    localparam coord_t L_HSTA = coord_t'(H_STA);
    localparam coord_t L_HEND = coord_t'(H_RES - 1);
    localparam coord_t L_HS0  = coord_t'(H_STA + H_FP);
    localparam coord_t L_HS1  = coord_t'(H_STA + H_FP + H_SYNC - 1);
    localparam coord_t L_VSTA = coord_t'(V_STA);
    localparam coord_t L_VEND = coord_t'(V_RES - 1);
    localparam coord_t L_VS0  = coord_t'(V_STA + V_FP);
    localparam coord_t L_VS1  = coord_t'(V_STA + V_FP + V_SYNC - 1);

    coord_t      r_sx;
    coord_t      r_sy;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic        r_fs;
    logic        r_ls;
    logic [15:0] r_frame_count;
    logic        r_first;

    coord_t      w_nx;
    coord_t      w_ny;
    logic        w_hwrap;
    logic        w_vwrap;

    always_comb begin
        w_hwrap = (r_sx == L_HEND);
        w_vwrap = (r_sy == L_VEND);
        w_nx    = w_hwrap ? L_HSTA : r_sx + L_ONE;
        w_ny    = r_sy;
        if (w_hwrap) begin
            w_ny = w_vwrap ? L_VSTA : r_sy + L_ONE;
        end
    end

    // Every output is computed from the next point so all of them move together.
    always_ff @(posedge video_clk_pix) begin
        if (video_rst_pix) begin
            r_sx          <= L_HEND;
            r_sy          <= L_VEND;
            r_hsync       <= !H_POL;
            r_vsync       <= !V_POL;
            r_de          <= 1'b0;
            r_fs          <= 1'b0;
            r_ls          <= 1'b0;
            r_frame_count <= 16'd0;
            r_first       <= 1'b1;
        end else begin
            r_sx    <= w_nx;
            r_sy    <= w_ny;
            r_hsync <= (w_nx >= L_HS0 && w_nx <= L_HS1) ? H_POL : !H_POL;
            r_vsync <= (w_ny >= L_VS0 && w_ny <= L_VS1) ? V_POL : !V_POL;
            r_de    <= !w_nx[COORDSPC-1] && !w_ny[COORDSPC-1];
            r_ls    <= w_hwrap;
            r_fs    <= w_hwrap && w_vwrap;
            // The reset-exit wrap lands on the origin but is not a completed frame.
            if (w_hwrap && w_vwrap && !r_first) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            r_first <= 1'b0;
        end
    end

    assign vid.sx           = r_sx;
    assign vid.sy           = r_sy;
    assign vid.hsync        = r_hsync;
    assign vid.vsync        = r_vsync;
    assign vid.video_enable = r_de;
    assign vid.frame_start  = r_fs;
    assign vid.line_start   = r_ls;
    assign vid.frame_count  = r_frame_count;
endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: reset vectors, arithmetic raster model, random
// resets, mid-frame reset and frame counter wrap.
module tb_video_timing;
    localparam int C     = 16;
    localparam int HR    = 8;
    localparam int HF    = 2;
    localparam int HS    = 2;
    localparam int HB    = 2;
    localparam int VR    = 4;
    localparam int VF    = 1;
    localparam int VS    = 1;
    localparam int VB    = 1;
    localparam int HSTA  = -(HF + HS + HB);
    localparam int VSTA  = -(VF + VS + VB);
    localparam int LINE  = HR + HF + HS + HB;
    localparam int LINES = VR + VF + VS + VB;
    localparam int FRAME = LINE * LINES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_timing_if #(.COORDSPC(C)) vp ();
    video_timing_if #(.COORDSPC(C)) vn ();

    video_timing #(
        .COORDSPC(C), .H_RES(HR), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_RES(VR), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut_p (
        .video_clk_pix(clk),
        .video_rst_pix(rst),
        .vid(vp.master)
    );

    video_timing #(
        .COORDSPC(C), .H_RES(HR), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_RES(VR), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dut_n (
        .video_clk_pix(clk),
        .video_rst_pix(rst),
        .vid(vn.master)
    );

    int errors = 0;
    int checks = 0;

    // Model: in reset, or t clocks past the origin of the first frame.
    bit m_rst = 1'b1;
    int m_t   = 0;
    int fcb_p = 0;
    int fcb_n = 0;

    typedef struct {
        int sx;
        int sy;
        bit hs;
        bit vs;
        bit de;
        bit fs;
        bit ls;
        int fc;
    } exp_t;

    typedef struct {
        bit rst;
        int sx;
        int sy;
        bit fs;
        bit ls;
        int fc;
    } vec_t;

    function automatic exp_t model(input int fcb);
        exp_t e;
        int h;
        int ln;
        if (m_rst) begin
            e = '{HR - 1, VR - 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        end else begin
            h    = m_t % LINE;
            ln   = (m_t / LINE) % LINES;
            e.sx = HSTA + h;
            e.sy = VSTA + ln;
            e.hs = (e.sx >= HSTA + HF) && (e.sx < HSTA + HF + HS);
            e.vs = (e.sy >= VSTA + VF) && (e.sy < VSTA + VF + VS);
            e.de = (e.sx >= 0) && (e.sy >= 0);
            e.ls = (h == 0);
            e.fs = (m_t % FRAME == 0);
            e.fc = (fcb + m_t / FRAME) & 32'hFFFF;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        exp_t e;
        e = model(fcb_p);
        chk("p.sx", vp.sx, e.sx);
        chk("p.sy", vp.sy, e.sy);
        chk("p.hsync", vp.hsync, e.hs);
        chk("p.vsync", vp.vsync, e.vs);
        chk("p.enable", vp.video_enable, e.de);
        chk("p.frame_start", vp.frame_start, e.fs);
        chk("p.line_start", vp.line_start, e.ls);
        chk("p.frame_count", vp.frame_count, e.fc);
        e = model(fcb_n);
        chk("n.sx", vn.sx, e.sx);
        chk("n.sy", vn.sy, e.sy);
        chk("n.hsync", vn.hsync, !e.hs);
        chk("n.vsync", vn.vsync, !e.vs);
        chk("n.enable", vn.video_enable, e.de);
        chk("n.frame_start", vn.frame_start, e.fs);
        chk("n.line_start", vn.line_start, e.ls);
        chk("n.frame_count", vn.frame_count, e.fc);
    endtask

    task automatic tick(input bit r);
        rst = r;
        @(posedge clk);
        if (r) begin
            m_rst = 1'b1;
            fcb_p = 0;
            fcb_n = 0;
        end else if (m_rst) begin
            m_rst = 1'b0;
            m_t   = 0;
        end else begin
            m_t++;
        end
        #1;
        cmp_all();
    endtask

    vec_t vecs[8];

    initial begin
        bit found;
        int hs_n;
        int vs_n;
        int de_n;
        int ls_n;

        vecs[0] = '{1'b1, 7, 3, 1'b0, 1'b0, 0};
        vecs[1] = '{1'b1, 7, 3, 1'b0, 1'b0, 0};
        vecs[2] = '{1'b1, 7, 3, 1'b0, 1'b0, 0};
        vecs[3] = '{1'b0, -6, -3, 1'b1, 1'b1, 0};
        vecs[4] = '{1'b0, -5, -3, 1'b0, 1'b0, 0};
        vecs[5] = '{1'b0, -4, -3, 1'b0, 1'b0, 0};
        vecs[6] = '{1'b0, -3, -3, 1'b0, 1'b0, 0};
        vecs[7] = '{1'b0, -2, -3, 1'b0, 1'b0, 0};

        for (int i = 0; i < 8; i++) begin
            tick(vecs[i].rst);
            chk("vec.sx", vp.sx, vecs[i].sx);
            chk("vec.sy", vp.sy, vecs[i].sy);
            chk("vec.frame_start", vp.frame_start, vecs[i].fs);
            chk("vec.line_start", vp.line_start, vecs[i].ls);
            chk("vec.frame_count", vp.frame_count, vecs[i].fc);
            chk("vec.n_hsync_idle", vn.hsync, vecs[i].rst ? 1 : (vecs[i].sx == -4 || vecs[i].sx == -3) ? 0 : 1);
        end

        // Second frame_start must come exactly one frame after reset exit.
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1'b0);
            if (vp.frame_start) begin
                found = 1'b1;
                break;
            end
        end
        chk("second_frame_found", found, 1);
        chk("frame_period", m_t, 98);
        chk("frame_count_one", vp.frame_count, 1);

        hs_n = 0;
        vs_n = 0;
        de_n = 0;
        ls_n = 0;
        for (int i = 0; i < FRAME; i++) begin
            hs_n += int'(vp.hsync);
            vs_n += int'(vp.vsync);
            de_n += int'(vp.video_enable);
            ls_n += int'(vp.line_start);
            if (vp.vsync) chk("vsync_line", vp.sy, -2);
            if (vp.hsync) chk("hsync_x", (vp.sx == -4 || vp.sx == -3), 1);
            tick(1'b0);
        end
        chk("hsync_per_frame", hs_n, 14);
        chk("vsync_per_frame", vs_n, 14);
        chk("enable_per_frame", de_n, 32);
        chk("line_starts", ls_n, 7);

        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (vp.sx == 3 && vp.sy == 1) begin
                found = 1'b1;
                break;
            end
            tick(1'b0);
        end
        chk("midframe_found", found, 1);
        tick(1'b1);
        chk("mid.rst_sx", vp.sx, 7);
        chk("mid.rst_sy", vp.sy, 3);
        chk("mid.rst_fs", vp.frame_start, 0);
        chk("mid.rst_ls", vp.line_start, 0);
        chk("mid.rst_fc", vp.frame_count, 0);
        chk("mid.rst_n_vsync", vn.vsync, 1);
        tick(1'b0);
        chk("mid.exit_sx", vp.sx, -6);
        chk("mid.exit_sy", vp.sy, -3);
        chk("mid.exit_fs", vp.frame_start, 1);
        chk("mid.exit_fc", vp.frame_count, 0);

        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 149) == 0);
        end

        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        for (int i = 0; i < 30; i++) tick(1'b0);
        force dut_p.r_frame_count = 16'hFFFF;
        #1;
        release dut_p.r_frame_count;
        fcb_p = 65535 - m_t / FRAME;
        tick(1'b0);
        chk("wrap.preload", vp.frame_count, 65535);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1'b0);
            if (vp.frame_start) begin
                found = 1'b1;
                break;
            end
        end
        chk("wrap.found", found, 1);
        chk("wrap.fc_zero", vp.frame_count, 0);
        tick(1'b0);
        chk("wrap.fs_one_cycle", vp.frame_start, 0);
        chk("wrap.fc_hold", vp.frame_count, 0);
        for (int i = 0; i < 120; i++) tick(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
